// File: rtl/eeprom_pkg.sv
// Shared types and helpers for the EEPROM command sequencer.
// One-hot state encoding, write pattern and default timings.
package eeprom_pkg;

  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int WR_GAP_CYC_DEF  = 1000;
  localparam logic [7:0] SEED_DEF = 8'hA5;
  localparam int TMR_W = 16;

  localparam int S_IDLE     = 0;
  localparam int S_WR_ISSUE = 1;
  localparam int S_WR_WAIT  = 2;
  localparam int S_WR_GAP   = 3;
  localparam int S_RD_ISSUE = 4;
  localparam int S_RD_WAIT  = 5;
  localparam int S_FINISH   = 6;
  localparam int S_NOP      = 7;

  typedef enum logic [7:0] {
    ST_IDLE     = 8'b0000_0001,
    ST_WR_ISSUE = 8'b0000_0010,
    ST_WR_WAIT  = 8'b0000_0100,
    ST_WR_GAP   = 8'b0000_1000,
    ST_RD_ISSUE = 8'b0001_0000,
    ST_RD_WAIT  = 8'b0010_0000,
    ST_FINISH   = 8'b0100_0000,
    ST_NOP      = 8'b1000_0000
  } state_t;

  function automatic logic [7:0] pattern(
    input logic [10:0] addr,
    input logic [7:0]  seed
  );
    return addr[7:0] ^ {5'b0, addr[10:8]} ^ seed;
  endfunction

endpackage

// File: rtl/eeprom_wait_timer.sv
// Loadable down-counter; expired while the count sits at zero.
// Shared between ACK timeout and post-write gap.
module eeprom_wait_timer
  import eeprom_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/eeprom_seq.sv
// Command sequencer feeding a serial EEPROM master: pattern
// writes, read-back verify, ACK timeout and error reporting.
module eeprom_seq
  import eeprom_pkg::*;
#(
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int         WR_GAP_CYC  = WR_GAP_CYC_DEF,
  parameter logic [7:0] SEED        = SEED_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        DO_WR,
  input  logic        DO_RD,
  input  logic [10:0] BASE_ADDR,
  input  logic [7:0]  LEN,
  output logic        WR,
  output logic        RD,
  output logic [10:0] ADDR,
  inout  wire  [7:0]  DATA,
  input  logic        ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        TIMEOUT,
  output logic [7:0]  ERR_CNT,
  output logic [10:0] FIRST_ERR_ADDR
);

  state_t state;
  state_t state_nx;

  logic             do_rd_q;
  logic [10:0]      base_q;
  logic [7:0]       len_q;
  logic [7:0]       idx;
  logic [10:0]      addr_q;
  logic             last;
  logic             idle_ok;
  logic             accept;
  logic             drive;
  logic [7:0]       exp_byte;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_exp;
  logic             tout_hit;

  assign exp_byte = pattern(addr_q, SEED);
  assign last     = (idx + 8'd1) == len_q;
  assign idle_ok  = state[S_IDLE] | state[S_FINISH]
                  | state[S_NOP];
  assign accept   = START & idle_ok;
  assign tout_hit = (state[S_WR_WAIT] | state[S_RD_WAIT])
                  & ~ACK & tmr_exp;

  assign tmr_load = state[S_WR_ISSUE] | state[S_RD_ISSUE]
                  | (state[S_WR_WAIT] & ACK);
  assign tmr_val  = state[S_WR_WAIT]
                  ? TMR_W'(WR_GAP_CYC - 1)
                  : TMR_W'(TIMEOUT_CYC - 1);

  eeprom_wait_timer #(.W(TMR_W)) u_timer (
    .clk      (CLK),
    .rst_n    (RESET),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state[S_IDLE],
      state[S_FINISH],
      state[S_NOP]: begin
        state_nx = ST_IDLE;
        if (START) begin
          if (LEN == 8'd0 || !(DO_WR || DO_RD))
            state_nx = ST_NOP;
          else if (DO_WR)
            state_nx = ST_WR_ISSUE;
          else
            state_nx = ST_RD_ISSUE;
        end
      end
      state[S_WR_ISSUE]: state_nx = ST_WR_WAIT;
      state[S_WR_WAIT]: begin
        if (ACK)          state_nx = ST_WR_GAP;
        else if (tmr_exp) state_nx = ST_FINISH;
      end
      state[S_WR_GAP]: begin
        if (tmr_exp) begin
          if (!last)        state_nx = ST_WR_ISSUE;
          else if (do_rd_q) state_nx = ST_RD_ISSUE;
          else              state_nx = ST_FINISH;
        end
      end
      state[S_RD_ISSUE]: state_nx = ST_RD_WAIT;
      state[S_RD_WAIT]: begin
        if (ACK)          state_nx = last ? ST_FINISH
                                          : ST_RD_ISSUE;
        else if (tmr_exp) state_nx = ST_FINISH;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Address is tracked alongside idx so it wraps at 2047 for free.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      do_rd_q        <= 1'b0;
      base_q         <= '0;
      len_q          <= '0;
      idx            <= '0;
      addr_q         <= '0;
      TIMEOUT        <= 1'b0;
      ERR_CNT        <= '0;
      FIRST_ERR_ADDR <= '0;
    end else begin
      if (accept) begin
        do_rd_q <= DO_RD;
        base_q  <= BASE_ADDR;
        len_q   <= LEN;
        idx     <= '0;
        addr_q  <= BASE_ADDR;
        TIMEOUT <= 1'b0;
        ERR_CNT <= '0;
      end
      if (state[S_WR_GAP] && tmr_exp) begin
        if (last) begin
          idx    <= '0;
          addr_q <= base_q;
        end else begin
          idx    <= idx + 8'd1;
          addr_q <= addr_q + 11'd1;
        end
      end
      if (state[S_RD_WAIT] && ACK) begin
        if (DATA != exp_byte) begin
          if (ERR_CNT == 8'd0)
            FIRST_ERR_ADDR <= addr_q;
          if (ERR_CNT != 8'hFF)
            ERR_CNT <= ERR_CNT + 8'd1;
        end
        idx    <= idx + 8'd1;
        addr_q <= addr_q + 11'd1;
      end
      if (tout_hit) TIMEOUT <= 1'b1;
    end
  end

  assign drive = state[S_WR_ISSUE] | state[S_WR_WAIT];
  assign DATA  = drive ? exp_byte : 8'hzz;
  assign WR    = state[S_WR_ISSUE];
  assign RD    = state[S_RD_ISSUE];
  assign ADDR  = addr_q;
  assign BUSY  = ~idle_ok;
  assign DONE  = state[S_FINISH] | state[S_NOP];

endmodule

// File: tb/tb_eeprom_seq.sv
// Directed bench for eeprom_seq with a delayed-ACK slave model.
// DATA carries pullups so a released bus reads back as 8'hFF.
module tb_eeprom_seq;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic        DO_WR = 1'b0;
  logic        DO_RD = 1'b0;
  logic [10:0] BASE_ADDR = '0;
  logic [7:0]  LEN = '0;
  logic        WR, RD, ACK, BUSY, DONE, TIMEOUT;
  logic [10:0] ADDR, FIRST_ERR_ADDR;
  logic [7:0]  ERR_CNT;
  wire  [7:0]  DATA;

  int checks = 0;
  int errors = 0;

  eeprom_seq dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .DO_WR(DO_WR), .DO_RD(DO_RD),
    .BASE_ADDR(BASE_ADDR), .LEN(LEN),
    .WR(WR), .RD(RD), .ADDR(ADDR), .DATA(DATA),
    .ACK(ACK), .BUSY(BUSY), .DONE(DONE),
    .TIMEOUT(TIMEOUT), .ERR_CNT(ERR_CNT),
    .FIRST_ERR_ADDR(FIRST_ERR_ADDR)
  );

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (DATA[g]);
  end

  // slave: ACK 20 cycles after each request
  logic [7:0]  mem [0:2047];
  logic        ack_en = 1'b1;
  logic        pend, p_wr, slv_drv;
  logic [10:0] p_addr;
  logic [7:0]  p_data, slv_q;
  int          p_cnt;

  assign DATA = slv_drv ? slv_q : 8'hzz;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pend <= 1'b0; ACK <= 1'b0; slv_drv <= 1'b0;
      p_wr <= 1'b0; p_addr <= '0; p_data <= '0;
      slv_q <= '0; p_cnt <= 0;
    end else begin
      ACK <= 1'b0;
      slv_drv <= 1'b0;
      if ((WR || RD) && ack_en) begin
        pend <= 1'b1; p_wr <= WR; p_addr <= ADDR;
        p_data <= DATA; p_cnt <= 19;
      end else if (pend) begin
        if (p_cnt == 0) begin
          pend <= 1'b0;
          ACK <= 1'b1;
          if (p_wr) mem[p_addr] <= p_data;
          else begin
            slv_drv <= 1'b1;
            slv_q <= mem[p_addr];
          end
        end else p_cnt <= p_cnt - 1;
      end
    end
  end

  // transaction monitor
  int          cyc = 0;
  int          wr_n = 0, rd_n = 0, done_n = 0, done_cyc = 0;
  logic [10:0] wr_addr [16];
  logic [7:0]  wr_data [16];
  int          wr_cyc  [16];
  logic [10:0] rd_addr [16];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (WR === 1'b1) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] = ADDR;
        wr_data[wr_n] = DATA;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n++;
    end
    if (RD === 1'b1) begin
      if (rd_n < 16) rd_addr[rd_n] = ADDR;
      rd_n++;
    end
    if (DONE === 1'b1) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  task automatic clear_log();
    wr_n = 0; rd_n = 0; done_n = 0;
  endtask

  task automatic do_start(input logic w, input logic r,
                          input logic [10:0] b,
                          input logic [7:0] l);
    DO_WR = w; DO_RD = r; BASE_ADDR = b; LEN = l;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (DONE !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (DONE !== 1'b1) begin
      errors++;
      $display("FAIL %s done_wait: DONE=%b required 1",
               tag, DONE);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if ({WR, RD, BUSY, DONE, TIMEOUT} !== 5'b0 ||
        ADDR !== 11'd0 || ERR_CNT !== 8'd0 ||
        FIRST_ERR_ADDR !== 11'd0) begin
      errors++;
      $display("FAIL reset_outs: WR%b RD%b B%b D%b T%b A%h E%h F%h required zeros",
               WR, RD, BUSY, DONE, TIMEOUT, ADDR, ERR_CNT,
               FIRST_ERR_ADDR);
    end
    checks++;
    if (DATA !== 8'hFF) begin
      errors++;
      $display("FAIL reset_data: DATA=%h required released (ff)",
               DATA);
    end
  endtask

  task automatic test_wr_rd();
    logic [10:0] ea [3];
    logic [7:0]  ed [3];
    ea = '{11'h010, 11'h011, 11'h012};
    ed = '{8'hB5, 8'hB4, 8'hB7};
    clear_log();
    do_start(1'b1, 1'b1, 11'h010, 8'd3);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL wr_rd_busy: BUSY=%b required 1", BUSY);
    end
    wait_done(8000, "wr_rd");
    checks++;
    if (wr_n != 3 || rd_n != 3 || done_n != 1) begin
      errors++;
      $display("FAIL wr_rd_counts: wr=%0d rd=%0d done=%0d required 3 3 1",
               wr_n, rd_n, done_n);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i] ||
          rd_addr[i] !== ea[i]) begin
        errors++;
        $display("FAIL wr_rd_txn%0d: wa=%h wd=%h ra=%h required %h %h %h",
                 i, wr_addr[i], wr_data[i], rd_addr[i],
                 ea[i], ed[i], ea[i]);
      end
    end
    checks++;
    if (ERR_CNT !== 8'd0 || TIMEOUT !== 1'b0 ||
        BUSY !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_status: E=%h T=%b B=%b required 00 0 0",
               ERR_CNT, TIMEOUT, BUSY);
    end
  endtask

  task automatic test_verify();
    mem[11'h100] = 8'hA4;
    mem[11'h101] = 8'hFF;
    clear_log();
    do_start(1'b0, 1'b1, 11'h100, 8'd2);
    wait_done(500, "verify");
    checks++;
    if (ERR_CNT !== 8'd1 || FIRST_ERR_ADDR !== 11'h101) begin
      errors++;
      $display("FAIL verify_err: E=%h F=%h required 01 101",
               ERR_CNT, FIRST_ERR_ADDR);
    end
    checks++;
    if (rd_n != 2 || wr_n != 0) begin
      errors++;
      $display("FAIL verify_counts: rd=%0d wr=%0d required 2 0",
               rd_n, wr_n);
    end
  endtask

  task automatic test_wrap();
    logic [10:0] ea [4];
    ea = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    clear_log();
    do_start(1'b1, 1'b0, 11'h7FE, 8'd4);
    wait_done(8000, "wrap");
    checks++;
    if (wr_n != 4 || rd_n != 0) begin
      errors++;
      $display("FAIL wrap_counts: wr=%0d rd=%0d required 4 0",
               wr_n, rd_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[i] !== ea[i]) begin
        errors++;
        $display("FAIL wrap_addr%0d: ADDR=%h required %h",
                 i, wr_addr[i], ea[i]);
      end
    end
    checks++;
    if (wr_data[1] !== 8'h5D || wr_data[2] !== 8'hA5) begin
      errors++;
      $display("FAIL wrap_data: %h %h required 5d a5",
               wr_data[1], wr_data[2]);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (wr_cyc[i] - wr_cyc[i-1] < 1000) begin
        errors++;
        $display("FAIL wrap_gap%0d: gap=%0d required >=1000",
                 i, wr_cyc[i] - wr_cyc[i-1]);
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    ack_en = 1'b0;
    clear_log();
    do_start(1'b1, 1'b0, 11'h020, 8'd2);
    while (wr_n == 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    repeat (10) @(negedge CLK);
    checks++;
    if (DATA !== 8'h85 || WR !== 1'b0) begin
      errors++;
      $display("FAIL tout_hold: DATA=%h WR=%b required 85 0",
               DATA, WR);
    end
    wait_done(5000, "tout");
    checks++;
    if (done_cyc - wr_cyc[0] != 4097) begin
      errors++;
      $display("FAIL tout_time: dt=%0d required 4097",
               done_cyc - wr_cyc[0]);
    end
    checks++;
    if (TIMEOUT !== 1'b1 || BUSY !== 1'b0 ||
        DATA !== 8'hFF || wr_n != 1 || done_n != 1) begin
      errors++;
      $display("FAIL tout_status: T=%b B=%b D=%h wr=%0d dn=%0d required 1 0 ff 1 1",
               TIMEOUT, BUSY, DATA, wr_n, done_n);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_len0();
    clear_log();
    do_start(1'b1, 1'b1, 11'h055, 8'd0);
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 ||
        TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL len0_done: DONE=%b BUSY=%b T=%b required 1 0 0",
               DONE, BUSY, TIMEOUT);
    end
    repeat (5) @(negedge CLK);
    checks++;
    if (wr_n != 0 || rd_n != 0 || done_n != 1) begin
      errors++;
      $display("FAIL len0_idle: wr=%0d rd=%0d dn=%0d required 0 0 1",
               wr_n, rd_n, done_n);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++)
      mem[11'h200 + 11'(i)] = 8'h00;
    clear_log();
    do_start(1'b0, 1'b1, 11'h200, 8'd5);
    repeat (3) @(negedge CLK);
    do_start(1'b1, 1'b1, 11'h300, 8'd9);
    wait_done(1000, "b2b");
    repeat (30) @(negedge CLK);
    checks++;
    if (rd_n != 5 || wr_n != 0 || done_n != 1) begin
      errors++;
      $display("FAIL b2b_counts: rd=%0d wr=%0d dn=%0d required 5 0 1",
               rd_n, wr_n, done_n);
    end
    checks++;
    if (rd_addr[4] !== 11'h204) begin
      errors++;
      $display("FAIL b2b_addr: ADDR=%h required 204", rd_addr[4]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_log();
    do_start(1'b1, 1'b0, 11'h040, 8'd3);
    while (wr_n == 0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    repeat (5) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    checks++;
    if ({WR, RD, BUSY, DONE} !== 4'b0 || ADDR !== 11'd0 ||
        DATA !== 8'hFF || ERR_CNT !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid: WR%b RD%b B%b D%b A%h DATA%h E%h required zeros, ff",
               WR, RD, BUSY, DONE, ADDR, DATA, ERR_CNT);
    end
    repeat (30) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (done_n != 0 || wr_n != 1) begin
      errors++;
      $display("FAIL rst_mid_quiet: dn=%0d wr=%0d required 0 1",
               done_n, wr_n);
    end
    clear_log();
    do_start(1'b1, 1'b0, 11'h060, 8'd1);
    wait_done(2000, "rst_rerun");
    checks++;
    if (wr_n != 1 || wr_addr[0] !== 11'h060 ||
        wr_data[0] !== 8'hC5 || done_n != 1) begin
      errors++;
      $display("FAIL rst_rerun: wr=%0d a=%h d=%h dn=%0d required 1 060 c5 1",
               wr_n, wr_addr[0], wr_data[0], done_n);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    repeat (3) @(negedge CLK);
    test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    test_wr_rd();
    test_verify();
    test_wrap();
    test_timeout();
    test_len0();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eeprom_seq.md
Name: eeprom_seq

Overview:
- Command sequencer directly upstream of the serial EEPROM read/write master (CLK/RESET/WR/RD/ADDR/DATA/ACK interface).
- Host gives one START with base address, length and mode. The block then streams byte writes and/or read-back-and-verify transactions to the master, one byte at a time, waiting for each ACK.
- Write data is a deterministic pattern, so read-back is self-checking.
- Reports busy/done, error count, first failing address and timeout.

Parameters:
- TIMEOUT_CYC, 4096: max CLK cycles from WR/RD issue to ACK before abort.
- WR_GAP_CYC, 1000: idle CLK cycles after each write ACK (EEPROM internal write time) before next transaction.
- SEED, 8'hA5: pattern seed; byte for address A = A[7:0] ^ A[10:8] ^ SEED.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- START  in  1  one-cycle request; ignored while BUSY
- DO_WR  in  1  perform write pass (sampled at START)
- DO_RD  in  1  perform read/verify pass (sampled at START)
- BASE_ADDR  in  11  first byte address (sampled at START)
- LEN  in  8  byte count, 0 = no-op (sampled at START)
- WR  out  1  one-cycle write request to master
- RD  out  1  one-cycle read request to master
- ADDR  out  11  byte address to master
- DATA  inout  8  driven with write byte during write transaction, else high-Z
- ACK  in  1  one-cycle completion pulse from master; DATA valid in that cycle for reads
- BUSY  out  1  sequence in progress
- DONE  out  1  one-cycle pulse at sequence end (normal or timeout)
- TIMEOUT  out  1  sticky; set on ACK timeout, cleared at next accepted START
- ERR_CNT  out  8  saturating mismatch count, cleared at accepted START
- FIRST_ERR_ADDR  out  11  address of first mismatch, valid when ERR_CNT != 0

Behaviour:
- Reset values (async, RESET low): WR=RD=0, ADDR=0, DATA high-Z, BUSY=0, DONE=0, TIMEOUT=0, ERR_CNT=0, FIRST_ERR_ADDR=0; state IDLE, all counters 0.
- A reset mid-sequence aborts immediately. No DONE is produced.
- States:
  - IDLE: on START, latch inputs, clear TIMEOUT/ERR_CNT, idx=0.
    - LEN=0 or DO_WR=DO_RD=0: DONE pulse next cycle, BUSY stays 0.
    - else if DO_WR: go to WR_ISSUE.
    - else: go to RD_ISSUE.
  - WR_ISSUE: WR=1 for exactly one cycle; ADDR=(BASE+idx) mod 2048; DATA driven with pattern. Go to WR_WAIT.
  - WR_WAIT: hold ADDR and DATA stable. On ACK go to WR_GAP. If the timer reaches TIMEOUT_CYC, go to FINISH with TIMEOUT=1.
  - WR_GAP: DATA released. After WR_GAP_CYC cycles, idx++. If idx==LEN: idx=0 and go to RD_ISSUE if DO_RD, else FINISH. Otherwise return to WR_ISSUE.
  - RD_ISSUE: RD=1 for one cycle, ADDR as above, DATA high-Z. Go to RD_WAIT.
  - RD_WAIT: on ACK, compare DATA with the expected pattern. On mismatch, ERR_CNT++ (saturates at 255); if this is the first mismatch, capture FIRST_ERR_ADDR. Then idx++; if idx==LEN go to FINISH, else RD_ISSUE. Timeout handling is the same as WR_WAIT.
  - FINISH: DONE=1 for one cycle, BUSY=0, return to IDLE.
- BUSY is high from the cycle after an accepted START through the cycle before the DONE pulse.
- Address wraps 2047 -> 0. Example: BASE=2046, LEN=4 gives 2046, 2047, 0, 1.
- The timeout counter restarts at each WR/RD issue. An ACK arriving on the same cycle the timer expires counts as success.
- ACK seen in IDLE or WR_GAP is ignored.
- START during BUSY is ignored with no side effects.
- Minimum per-byte latency: write = 1 + ACK latency + WR_GAP_CYC; read = 1 + ACK latency.

Decomposition:
- Package eeprom_pkg holds:
  - state encoding constants (one-hot, 8 states);
  - the pattern function (addr, seed);
  - default TIMEOUT_CYC and WR_GAP_CYC values.
- Sub-module eeprom_wait_timer: loadable down-counter with an expire flag, shared for timeout and write gap (only one is ever active).

Test Plan:
- DO_WR=1, DO_RD=1, BASE=0x010, LEN=3; slave model acks after 20 cycles -> 3 WR pulses with ADDR 0x010/0x011/0x012 and DATA 0xB5/0xB4/0xB7, then 3 RD pulses; ERR_CNT=0, single DONE pulse, TIMEOUT=0.
- Read-only, LEN=2, BASE=0x100; model returns 0xFF at 0x101 -> ERR_CNT=1, FIRST_ERR_ADDR=0x101.
- BASE=0x7FE, LEN=4, write-only -> ADDR sequence 0x7FE, 0x7FF, 0x000, 0x001; each WR separated by at least WR_GAP_CYC cycles.
- No ACK from the model -> WR stays low after issue; at TIMEOUT_CYC, DONE pulses, TIMEOUT=1, BUSY=0, DATA returns to high-Z.
- START with LEN=0 -> DONE the next cycle, no WR/RD activity. A second START while BUSY in a 5-byte run -> ignored, still exactly 5 transactions.
- RESET low in the middle of WR_WAIT -> all outputs take reset values asynchronously and DATA goes high-Z. A new START after release runs normally from idx 0.
